// File: rtl/bus_scheduler.sv
// bus_scheduler
// Time-division scheduler for the shared CPU/RAM/IO bus. Each frame of
// FRAME_CYCLES sys_clock_i periods is one CPU clock cycle. The frame opens
// with a Wishbone slot (cycles 0..WB_SLOT_END). The CPU slot follows and
// runs to the end of the frame.
//
// Ports:
//   sys_clock_i   system clock (only clock)
//   sys_reset_i   synchronous active-high reset
//   wb_req_i      Wishbone bridge access request (sampled at last frame cycle)
//   wb_grant_o    bus owned by the Wishbone bridge for the current slot
//   wb_strobe_o   one-cycle pulse: Wishbone read data valid / write commit
//   wb_ack_o      one-cycle pulse: Wishbone access complete
//   cpu_halt_i    CPU stall request (sampled at CPU_CLOCK_RISE-1)
//   cpu_clock_o   CPU PHI2
//   cpu_be_o      CPU bus enable
//   cpu_ready_o   CPU RDY
//   cpu_strobe_o  one-cycle pulse: CPU access commit point
//   cycle_o       current frame cycle
module bus_scheduler #(
  parameter int FRAME_CYCLES   = 64,
  parameter int WB_SLOT_END    = 15,
  parameter int WB_STROBE_AT   = 12,
  parameter int CPU_CLOCK_RISE = 32,
  parameter int CPU_STROBE_AT  = 60
) (
  input  logic                            sys_clock_i,
  input  logic                            sys_reset_i,
  input  logic                            wb_req_i,
  output logic                            wb_grant_o,
  output logic                            wb_strobe_o,
  output logic                            wb_ack_o,
  input  logic                            cpu_halt_i,
  output logic                            cpu_clock_o,
  output logic                            cpu_be_o,
  output logic                            cpu_ready_o,
  output logic                            cpu_strobe_o,
  output logic [$clog2(FRAME_CYCLES)-1:0] cycle_o
);

  localparam int CW = $clog2(FRAME_CYCLES);

  localparam logic [CW-1:0] LAST_CYC    = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_END    = CW'(WB_SLOT_END);
  localparam logic [CW-1:0] WB_STB_CYC  = CW'(WB_STROBE_AT);
  localparam logic [CW-1:0] CLK_RISE    = CW'(CPU_CLOCK_RISE);
  localparam logic [CW-1:0] HALT_SMP    = CW'(CPU_CLOCK_RISE - 1);
  localparam logic [CW-1:0] CPU_STB_CYC = CW'(CPU_STROBE_AT);

  logic [CW-1:0] cycle_q, cycle_d;
  // slot_q: the Wishbone slot of the current frame is granted.
  // live_q: at least one frame boundary has passed since reset. Before that,
  //         the first Wishbone slot belongs to nobody and the bus is left undriven.
  logic          slot_q, slot_d;
  logic          live_q, live_d;
  logic          wb_grant_q, wb_grant_d;
  logic          wb_strobe_q, wb_strobe_d;
  logic          wb_ack_q, wb_ack_d;
  logic          cpu_clock_q, cpu_clock_d;
  logic          cpu_be_q, cpu_be_d;
  logic          cpu_ready_q, cpu_ready_d;
  logic          cpu_strobe_q, cpu_strobe_d;

  // Outputs are registered, so each one is decoded from the cycle value
  // that the counter is about to take (cycle_d). The slot and ready
  // decisions are also taken from their next-state values.
  always_comb begin
    cycle_d      = cycle_q + 1'b1;  // FRAME_CYCLES is a power of 2, so this wraps
    slot_d       = (cycle_q == LAST_CYC) ? wb_req_i : slot_q;
    live_d       = live_q | (cycle_q == LAST_CYC);
    cpu_ready_d  = (cycle_q == HALT_SMP) ? ~cpu_halt_i : cpu_ready_q;

    wb_grant_d   = slot_d & (cycle_d <= SLOT_END);
    wb_strobe_d  = slot_d & (cycle_d == WB_STB_CYC);
    wb_ack_d     = slot_d & (cycle_d == SLOT_END);
    cpu_clock_d  = (cycle_d >= CLK_RISE);
    cpu_be_d     = (cycle_d > SLOT_END) | (live_d & ~slot_d);
    cpu_strobe_d = (cycle_d == CPU_STB_CYC);
  end

  always_ff @(posedge sys_clock_i) begin
    if (sys_reset_i) begin
      cycle_q      <= '0;
      slot_q       <= 1'b0;
      live_q       <= 1'b0;
      wb_grant_q   <= 1'b0;
      wb_strobe_q  <= 1'b0;
      wb_ack_q     <= 1'b0;
      cpu_clock_q  <= 1'b0;
      cpu_be_q     <= 1'b0;
      cpu_ready_q  <= 1'b0;
      cpu_strobe_q <= 1'b0;
    end else begin
      cycle_q      <= cycle_d;
      slot_q       <= slot_d;
      live_q       <= live_d;
      wb_grant_q   <= wb_grant_d;
      wb_strobe_q  <= wb_strobe_d;
      wb_ack_q     <= wb_ack_d;
      cpu_clock_q  <= cpu_clock_d;
      cpu_be_q     <= cpu_be_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_strobe_q <= cpu_strobe_d;
    end
  end

  assign cycle_o      = cycle_q;
  assign wb_grant_o   = wb_grant_q;
  assign wb_strobe_o  = wb_strobe_q;
  assign wb_ack_o     = wb_ack_q;
  assign cpu_clock_o  = cpu_clock_q;
  assign cpu_be_o     = cpu_be_q;
  assign cpu_ready_o  = cpu_ready_q;
  assign cpu_strobe_o = cpu_strobe_q;

endmodule

// File: tb/tb_bus_scheduler.sv
// tb_bus_scheduler
// Directed and randomized stimulus for bus_scheduler. A frame-level
// reference model tracks the frame position, the grant decision for the
// current frame and the RDY value. Every DUT output is compared against it
// one time unit after each rising edge.
module tb_bus_scheduler;

  localparam int F  = 64;
  localparam int SE = 15;
  localparam int WS = 12;
  localparam int CR = 32;
  localparam int CS = 60;

  logic       clk = 1'b0;
  logic       rst, req, halt;
  logic       wb_grant_o, wb_strobe_o, wb_ack_o;
  logic       cpu_clock_o, cpu_be_o, cpu_ready_o, cpu_strobe_o;
  logic [5:0] cycle_o;

  always #5 clk = ~clk;

  bus_scheduler dut (
    .sys_clock_i (clk),
    .sys_reset_i (rst),
    .wb_req_i    (req),
    .wb_grant_o  (wb_grant_o),
    .wb_strobe_o (wb_strobe_o),
    .wb_ack_o    (wb_ack_o),
    .cpu_halt_i  (halt),
    .cpu_clock_o (cpu_clock_o),
    .cpu_be_o    (cpu_be_o),
    .cpu_ready_o (cpu_ready_o),
    .cpu_strobe_o(cpu_strobe_o),
    .cycle_o     (cycle_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int m_cycle   = 0;
  bit m_granted = 0;  // this frame's Wishbone slot is owned by the bridge
  bit m_first   = 1;  // still in the first frame after reset
  bit m_ready   = 0;

  // Event counters, cleared by each directed segment
  int  ack_cnt = 0, wbs_cnt = 0, gslot_cnt = 0;
  logic prev_grant = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (model cycle %0d)", tag, obs, exp, m_cycle);
    end
  endtask

  task automatic step();
    int c;
    @(posedge clk);
    #1;
    // Inputs have not yet changed, so req/halt/rst hold the values sampled at this edge.
    if (rst) begin
      m_cycle   = 0;
      m_granted = 0;
      m_first   = 1;
      m_ready   = 0;
    end else begin
      if (m_cycle == F - 1) begin
        m_granted = req;
        m_first   = 0;
      end
      if (m_cycle == CR - 1) m_ready = !halt;
      m_cycle = (m_cycle + 1) % F;
    end
    c = m_cycle;
    chk("cycle",      32'(cycle_o),      32'(c));
    chk("wb_grant",   32'(wb_grant_o),   32'(m_granted && c <= SE));
    chk("wb_strobe",  32'(wb_strobe_o),  32'(m_granted && c == WS));
    chk("wb_ack",     32'(wb_ack_o),     32'(m_granted && c == SE));
    chk("cpu_clock",  32'(cpu_clock_o),  32'(!rst && c >= CR));
    chk("cpu_be",     32'(cpu_be_o),     32'(c > SE || (!m_first && !m_granted)));
    chk("cpu_ready",  32'(cpu_ready_o),  32'(m_ready));
    chk("cpu_strobe", 32'(cpu_strobe_o), 32'(c == CS));
    chk("grant_be_excl",   32'(wb_grant_o & cpu_be_o),     32'd0);
    chk("strobe_excl",     32'(wb_strobe_o & cpu_strobe_o), 32'd0);
    if (wb_ack_o)    ack_cnt++;
    if (wb_strobe_o) wbs_cnt++;
    if (wb_grant_o && !prev_grant) gslot_cnt++;
    prev_grant = wb_grant_o;
  endtask

  task automatic run_until(input int target);
    int guard = 0;
    while (m_cycle != target && guard < 2 * F) begin
      step();
      guard++;
    end
    chk("reach_cycle", 32'(cycle_o), 32'(target));
  endtask

  task automatic clear_counts();
    ack_cnt   = 0;
    wbs_cnt   = 0;
    gslot_cnt = 0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 1'b1;  // high during reset: must not produce a grant afterwards
    halt = 1'b0;
    repeat (3) step();
    chk("reset_cycle", 32'(cycle_o), 32'd0);
    chk("reset_be",    32'(cpu_be_o), 32'd0);
    req = 1'b0;
    rst = 1'b0;

    // Two idle frames: PHI2, BE and CPU strobe pattern.
    clear_counts();
    repeat (2 * F) step();
    chk("idle_grants", 32'(gslot_cnt), 32'd0);

    // Request raised at cycle 40: granted in the next frame only.
    run_until(40);
    req = 1'b1;
    clear_counts();
    run_until(63);
    chk("req40_no_grant_yet", 32'(gslot_cnt), 32'd0);
    step();
    chk("req40_grant_c0", 32'(wb_grant_o), 32'd1);
    req = 1'b0;
    step();
    run_until(0);
    step();
    run_until(20);
    chk("req40_slots",   32'(gslot_cnt), 32'd1);
    chk("req40_strobes", 32'(wbs_cnt),   32'd1);
    chk("req40_acks",    32'(ack_cnt),   32'd1);

    // Request held high across four sample points.
    run_until(40);
    req = 1'b1;
    clear_counts();
    repeat (4) begin
      run_until(63);
      step();
    end
    req = 1'b0;
    run_until(20);
    chk("held4_slots",   32'(gslot_cnt), 32'd4);
    chk("held4_strobes", 32'(wbs_cnt),   32'd4);
    chk("held4_acks",    32'(ack_cnt),   32'd4);

    // Sampled high at 63, dropped at cycle 2 of the slot: no abort.
    run_until(62);
    req = 1'b1;
    clear_counts();
    step();
    step();
    step();
    step();
    req = 1'b0;
    run_until(15);
    chk("drop_grant_c15", 32'(wb_grant_o), 32'd1);
    chk("drop_ack_c15",   32'(wb_ack_o),   32'd1);
    run_until(20);
    chk("drop_acks", 32'(ack_cnt), 32'd1);

    // Halt sampled at 31 only.
    run_until(31);
    halt = 1'b1;
    step();
    chk("halt_rdy_low", 32'(cpu_ready_o), 32'd0);
    run_until(45);
    halt = 1'b0;
    run_until(31);
    chk("halt_toggle45_ignored", 32'(cpu_ready_o), 32'd0);
    step();
    chk("halt_release_rdy", 32'(cpu_ready_o), 32'd1);
    run_until(45);
    halt = 1'b1;
    run_until(31);
    halt = 1'b0;
    step();
    chk("halt_rdy_kept", 32'(cpu_ready_o), 32'd1);

    // Reset at cycle 8 of a granted slot.
    run_until(50);
    req = 1'b1;
    run_until(8);
    chk("abort_grant_before", 32'(wb_grant_o), 32'd1);
    req = 1'b0;
    rst = 1'b1;
    clear_counts();
    step();
    rst = 1'b0;
    chk("abort_grant",  32'(wb_grant_o),  32'd0);
    chk("abort_cycle",  32'(cycle_o),     32'd0);
    chk("abort_ready",  32'(cpu_ready_o), 32'd0);
    repeat (F) step();
    chk("abort_no_ack",   32'(ack_cnt),   32'd0);
    chk("abort_no_grant", 32'(gslot_cnt), 32'd0);

    // Randomized traffic with occasional resets.
    repeat (10 * F) begin
      if ($urandom_range(0, 7) == 0) req = ~req;
      halt = 1'($urandom_range(0, 1));
      rst  = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
